// File: rtl/mult_accum_sat_if.sv
// ============================================================================
// Module      : mult_accum_sat_if
// Description : Product-in / frame-result-out handshake bundle for
//               mult_accum_sat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_accum_sat_if #(
  parameter int IN_WIDTH  = 11,
  parameter int OUT_WIDTH = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_sat;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/mult_accum_sat.sv
// ============================================================================
// Module      : mult_accum_sat
// Description : Sums NUM_TERMS signed products per frame and emits one
//               saturated result per frame over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_accum_sat #(
  parameter int IN_WIDTH  = 11,
  parameter int NUM_TERMS = 4,
  parameter int OUT_WIDTH = 12
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  mult_accum_sat_if.slave  bus
);

  localparam int ACC_WIDTH = (NUM_TERMS == 1) ? IN_WIDTH : IN_WIDTH + $clog2(NUM_TERMS);
  localparam int CNT_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_TERMS - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t                       r_state,     w_state_nxt;
  logic signed [ACC_WIDTH-1:0]  r_acc,       w_acc_nxt;
  logic        [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
  logic                         r_in_ready,  w_in_ready_nxt;
  logic                         r_out_valid, w_out_valid_nxt;
  logic        [OUT_WIDTH-1:0]  r_out_data,  w_out_data_nxt;
  logic                         r_out_sat,   w_out_sat_nxt;

  logic signed [ACC_WIDTH-1:0]  w_in_ext;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic        [OUT_WIDTH-1:0]  w_sat_data;
  logic                         w_sat_flag;
  logic                         w_accept;

  // The accumulator is sized for NUM_TERMS full-scale products, so this add
  // can never wrap.
  assign w_in_ext = ACC_WIDTH'($signed(bus.in_data));
  assign w_sum    = r_acc + w_in_ext;
  assign w_accept = bus.in_valid && r_in_ready;

  generate
    if (OUT_WIDTH >= ACC_WIDTH) begin : g_sat_ext
      assign w_sat_data = OUT_WIDTH'(w_sum);
      assign w_sat_flag = 1'b0;
    end else begin : g_sat_clip
      localparam logic signed [ACC_WIDTH-1:0] c_max =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      localparam logic signed [ACC_WIDTH-1:0] c_min =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

      always_comb begin
        w_sat_data = w_sum[OUT_WIDTH-1:0];
        w_sat_flag = 1'b0;
        if (w_sum > c_max) begin
          w_sat_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
          w_sat_flag = 1'b1;
        end else if (w_sum < c_min) begin
          w_sat_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
          w_sat_flag = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_sat_nxt   = r_out_sat;

    case (r_state)
      ST_ACCUM: begin
        // Ready is low only on the first cycle out of reset.
        w_in_ready_nxt = 1'b1;
        if (bus.flush) begin
          w_acc_nxt = '0;
          w_cnt_nxt = '0;
        end else if (w_accept) begin
          if (r_cnt == c_last) begin
            w_out_data_nxt  = w_sat_data;
            w_out_sat_nxt   = w_sat_flag;
            w_out_valid_nxt = 1'b1;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_in_ready_nxt  = 1'b0;
            w_state_nxt     = ST_HOLD;
          end else begin
            w_acc_nxt = w_sum;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        // Result and flags stay put; only the handshake bits change on release.
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = ST_ACCUM;
        end
      end

      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_sat   <= w_out_sat_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

endmodule

`default_nettype wire

// File: tb/tb_mult_accum_sat.sv
// ============================================================================
// Module      : tb_mult_accum_sat
// Description : Directed self-checking bench for mult_accum_sat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_accum_sat;

  localparam int IN_WIDTH  = 11;
  localparam int NUM_TERMS = 4;
  localparam int OUT_WIDTH = 12;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mult_accum_sat_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  mult_accum_sat #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_TERMS (NUM_TERMS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int valid, input int data, input int sat);
    check({tag, "_valid"}, int'(bus.out_valid), valid);
    check({tag, "_data"},  int'($signed(bus.out_data)), data);
    check({tag, "_sat"},   int'(bus.out_sat), sat);
  endtask

  // Present one product and hold it until the edge that accepts it.
  task automatic send(input int val);
    int waits;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = IN_WIDTH'(val);
    while (!bus.in_ready && waits < 20) begin
      tick();
      waits++;
    end
    check("send_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic frame(input int a, input int b, input int c, input int d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset and bring-up
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", int'(bus.in_ready), 0);
      check_out("rst", 0, 0, 0);
    end
    rst_n = 1'b1;
    #1;
    check("release_ready_low", int'(bus.in_ready), 0);
    tick();
    check("release_ready_high", int'(bus.in_ready), 1);

    // Normal frame: 5 - 3 + 100 - 200 = -98
    frame(5, -3, 100, -200);
    check_out("normal", 1, -98, 0);
    check("normal_bubble", int'(bus.in_ready), 0);
    tick();
    check("normal_release_valid", int'(bus.out_valid), 0);
    check("normal_release_ready", int'(bus.in_ready), 1);
    check("normal_keep_data", int'($signed(bus.out_data)), -98);

    // Saturation both ways
    frame(1023, 1023, 1023, 1023);
    check_out("sat_pos", 1, 2047, 1);
    tick();
    frame(-1024, -1024, -1024, -1024);
    check_out("sat_neg", 1, -2048, 1);
    tick();

    // Backpressure: result held, extra input ignored
    bus.out_ready = 1'b0;
    frame(1, 1, 1, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_WIDTH'(77);
    for (int i = 0; i < 5; i++) begin
      check_out("bp_hold", 1, 4, 0);
      check("bp_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_ready", int'(bus.in_ready), 1);
    frame(2, 2, 2, 2);
    check_out("bp_next", 1, 8, 0);
    tick();

    // Flush discards partial frame and the coincident product
    send(7);
    send(9);
    bus.in_valid = 1'b1;
    bus.in_data  = IN_WIDTH'(50);
    bus.flush    = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b0;
    frame(1, 2, 3, 4);
    check_out("flush_next", 1, 10, 0);
    // Flush while holding a result is ignored
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check_out("flush_in_hold", 1, 10, 0);
    bus.out_ready = 1'b1;
    tick();
    check("flush_hold_release", int'(bus.out_valid), 0);

    // Asynchronous reset in the middle of a frame
    send(100);
    send(100);
    send(100);
    #3 rst_n = 1'b0;
    #1;
    check("async_in_ready", int'(bus.in_ready), 0);
    check_out("async", 0, 0, 0);
    #1 rst_n = 1'b1;
    tick();
    check("async_ready_back", int'(bus.in_ready), 1);
    frame(10, 10, 10, 10);
    check_out("async_next", 1, 40, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_accum_sat.md
Name: mult_accum_sat

Overview:
- Downstream consumer of the constant-coefficient signed multiplier; feeds the neuron adder/activation stage.
- Accepts the multiplier's signed products over a valid/ready handshake.
- Sums a fixed number of products per frame and emits one saturated result per frame, with backpressure.
- Single clock domain, asynchronous active-low reset.

Parameters:
- IN_WIDTH, 11, width of each signed product (multiplier output width).
- NUM_TERMS, 4, products summed per frame; legal values are 1 or more.
- OUT_WIDTH, 12, width of the signed saturated result.
- ACC_WIDTH, derived as IN_WIDTH + clog2(NUM_TERMS), or IN_WIDTH when NUM_TERMS=1. Internal accumulator width; never overflows. Localparam only, not overridable.

Ports:
- clk  input  1  Rising-edge clock.
- rst_n  input  1  Asynchronous active-low reset.
- in_valid  input  1  in_data holds a product.
- in_ready  output  1  Block can accept a product.
- in_data  input  IN_WIDTH  Signed two's-complement product.
- flush  input  1  Synchronous abort of the partial frame.
- out_valid  output  1  out_data holds a frame result.
- out_ready  input  1  Downstream accepts the result.
- out_data  output  OUT_WIDTH  Signed saturated frame sum.
- out_sat  output  1  Result was clipped; qualified by out_valid.

Behaviour:
- Interface: one clock (clk) and an asynchronous active-low reset (rst_n).
- Reset (rst_n low, asynchronous, including mid-frame or mid-hold):
  - acc=0, cnt=0, state=ACCUM.
  - in_ready=0, out_valid=0, out_data=0, out_sat=0.
  - Any partial frame or held result is lost.
- in_ready is registered. It rises on the first clk edge after rst_n deasserts.
- Accept: a product is accepted on a rising edge where in_valid && in_ready. No other in_data is consumed. in_data is sign-extended to ACC_WIDTH.
- State ACCUM (in_ready=1):
  - Accept with cnt < NUM_TERMS-1: acc += in_data, cnt += 1.
  - Accept with cnt = NUM_TERMS-1 (last term):
    - Compute sum = acc + in_data.
    - Register out_data = sat(sum), out_sat accordingly, out_valid=1.
    - Set acc=0, cnt=0, in_ready=0, state=HOLD.
  - Latency: result is visible the cycle after the last accept.
- State HOLD (in_ready=0):
  - out_data and out_sat are held stable while out_valid && !out_ready.
  - Edge with out_ready=1: out_valid=0, in_ready=1, state=ACCUM. out_data and out_sat keep their last values.
  - This gives exactly one bubble cycle between frames.
- Saturation, with MAX = 2^(OUT_WIDTH-1)-1 and MIN = -2^(OUT_WIDTH-1):
  - sum > MAX gives MAX with out_sat=1.
  - sum < MIN gives MIN with out_sat=1.
  - Otherwise sum is truncated to OUT_WIDTH (lossless) with out_sat=0.
  - If OUT_WIDTH >= ACC_WIDTH, sum is sign-extended and out_sat is constant 0.
- flush:
  - In ACCUM: acc=0, cnt=0 next edge.
  - A product presented in the same cycle as flush is discarded: flush wins, and in_ready stays 1.
  - In HOLD: ignored; the held result is still delivered.
- Edge cases:
  - in_valid while in_ready=0 has no effect. Upstream must hold the data; the block does not buffer.
  - NUM_TERMS=1: every accept produces a result.
  - Accumulation is exact, with no internal wrap-around at any cnt.

Test Plan:
- Reset/bring-up: rst_n low 3 cycles, then high.
  - All outputs 0 while rst_n is low.
  - in_ready=1 exactly one edge after release.
- Normal frame: products 5, -3, 100, -200 back-to-back, out_ready=1.
  - out_valid=1 the cycle after the 4th accept, out_data=-98, out_sat=0.
  - in_ready=0 for one cycle, then 1.
- Saturation: four products of 1023 give out_data=2047, out_sat=1. Four products of -1024 give out_data=-2048, out_sat=1.
- Backpressure: frame 1,1,1,1 with out_ready=0 for 5 cycles.
  - out_data=4 stable, out_valid=1, in_ready=0 throughout; new in_valid is ignored.
  - out_ready=1 releases it. The next frame 2,2,2,2 gives 8.
- Flush: accept 7, 9, then assert flush together with in_valid on 50.
  - The 50 is not counted.
  - Next frame 1,2,3,4 gives out_data=10.
- Async reset mid-frame: accept 3 terms, pulse rst_n low between clock edges.
  - Outputs clear immediately.
  - After release, 4 new terms of 10 give 40 (no residue from the aborted frame).
